// File: rtl/aes_key_expander_if.sv
// Handshake and read-port bundle between the round pipeline and the AES key-schedule engine.
interface aes_key_expander_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic         err;
  logic [3:0]   nr;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic [127:0] rd_data;

  modport master (
    output start, key_len, key_in, rd_en, rd_round,
    input  busy, done, key_valid, err, nr, rd_data
  );

  modport slave (
    input  start, key_len, key_in, rd_en, rd_round,
    output busy, done, key_valid, err, nr, rd_data
  );
endinterface

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule: one schedule word per clock into a word store,
// 128-bit round keys fetched by round index through a registered read port.

module sbox (
  input  logic [7:0] in,
  output logic [7:0] aes_sbox
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Multiplicative inverse as in^254 (product of in^2..in^128), then the affine map.
  always_comb begin
    sq  = in;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    aes_sbox = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expander #(
  parameter int unsigned MAX_NK          = 8,
  parameter bit          RD_ZERO_INVALID = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_key_expander_if.slave bus
);
  localparam int unsigned DEPTH = 4 * (MAX_NK + 7);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned WINW  = 32 * MAX_NK;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [31:0]     store [DEPTH];
  logic [WINW-1:0] win;
  logic [5:0]      idx;
  logic [5:0]      last_idx;
  logic [2:0]      phase;
  logic [7:0]      rcon;
  logic [3:0]      nk_q;
  logic [3:0]      nr_lat;

  logic [3:0]  req_nk_c;
  logic [3:0]  req_nr_c;
  logic        req_ok_c;
  logic        accept_c;
  logic        last_c;
  logic [31:0] w_prev_c;
  logic [31:0] w_old_c;
  logic [31:0] sub_in_c;
  logic [31:0] sub_out_c;
  logic [31:0] temp_c;
  logic [31:0] new_w_c;

  assign req_nk_c = 4'd4 + {1'b0, bus.key_len, 1'b0};
  assign req_nr_c = req_nk_c + 4'd6;
  assign req_ok_c = (bus.key_len != 2'd3) && (32'(req_nk_c) <= MAX_NK);
  assign accept_c = (state == IDLE) && bus.start && req_ok_c;
  assign last_c   = (state == BUSY) && (idx == last_idx);

  // Window keeps the last Nk words, newest in the low word; w[i-Nk] sits Nk-1 words up.
  assign w_prev_c = win[31:0];
  assign w_old_c  = 32'(win >> {nk_q - 4'd1, 5'b0});
  assign sub_in_c = (phase == 3'd0) ? {w_prev_c[23:0], w_prev_c[31:24]} : w_prev_c;

  for (genvar g = 0; g < 4; g++) begin : g_sub
    sbox u_sbox (
      .in       (sub_in_c[8*g +: 8]),
      .aes_sbox (sub_out_c[8*g +: 8])
    );
  end

  always_comb begin
    temp_c = w_prev_c;
    if (phase == 3'd0) begin
      temp_c = sub_out_c ^ {rcon, 24'h000000};
    end else if (nk_q == 4'd8 && phase == 3'd4) begin
      temp_c = sub_out_c;
    end
  end

  assign new_w_c = w_old_c ^ temp_c;

  // Control FSM, schedule sequencing and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.key_valid <= 1'b0;
      bus.err       <= 1'b0;
      bus.nr        <= 4'd0;
      idx           <= 6'd0;
      last_idx      <= 6'd0;
      phase         <= 3'd0;
      rcon          <= 8'h01;
      nk_q          <= 4'd4;
      nr_lat        <= 4'd0;
      win           <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (req_ok_c) begin
              state         <= BUSY;
              bus.busy      <= 1'b1;
              bus.key_valid <= 1'b0;
              idx           <= {2'b00, req_nk_c};
              last_idx      <= {req_nr_c, 2'b11};
              nk_q          <= req_nk_c;
              nr_lat        <= req_nr_c;
              phase         <= 3'd0;
              rcon          <= 8'h01;
              win           <= WINW'(bus.key_in >> {4'd8 - req_nk_c, 5'b0});
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        BUSY: begin
          win   <= {win[WINW-33:0], new_w_c};
          phase <= (phase == 3'(nk_q - 4'd1)) ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (last_c) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.key_valid <= 1'b1;
            bus.nr        <= nr_lat;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word store: cipher key words on acceptance, one generated word per busy cycle.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      for (int k = 0; k < int'(MAX_NK); k++) begin
        if (32'(k) < 32'(req_nk_c)) store[AW'(k)] <= bus.key_in[255-32*k -: 32];
      end
    end else if (state == BUSY) begin
      store[AW'(idx)] <= new_w_c;
    end
  end

  // Registered round-key read; samples the store before any same-edge update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data <= '0;
    end else if (bus.rd_en) begin
      if ((bus.rd_round > bus.nr) || (RD_ZERO_INVALID && !bus.key_valid)) begin
        bus.rd_data <= '0;
      end else begin
        bus.rd_data <= {store[AW'({bus.rd_round, 2'd0})], store[AW'({bus.rd_round, 2'd1})],
                        store[AW'({bus.rd_round, 2'd2})], store[AW'({bus.rd_round, 2'd3})]};
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: known-answer table, corner sequences, random keys vs model.
module tb_aes_key_expander;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_expander_if bus ();
  aes_key_expander_if bus4 ();

  aes_key_expander #(.MAX_NK(8), .RD_ZERO_INVALID(1'b1)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus)
  );
  aes_key_expander #(.MAX_NK(4), .RD_ZERO_INVALID(1'b1)) dut4 (
    .clk (clk), .rst_n (rst_n), .bus (bus4)
  );

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int tests = 0;
  int fails = 0;

  logic [7:0]  sb_tab [256];
  logic [7:0]  rcon_tab [11];
  logic [31:0] mw [60];

  typedef struct {
    int           kl;
    logic [255:0] key;
    int           round;
    logic [127:0] exp;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference GF(2^8) product: carry-less multiply then reduce by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(b), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
      sb_tab[b] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
  endfunction

  task automatic model_expand(input int nk, input logic [255:0] key);
    logic [31:0] t;
    int total;
    total = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = mw[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic read_rk(input int r, output logic [127:0] d);
    bus.rd_en = 1'b1;
    bus.rd_round = 4'(r);
    tick();
    bus.rd_en = 1'b0;
    d = bus.rd_data;
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    check({name, " busy cycles"}, 128'(n), 128'(exp_cycles));
    check({name, " done"}, 128'(bus.done), 128'(1));
    check({name, " key_valid"}, 128'(bus.key_valid), 128'(1));
  endtask

  task automatic expand(input int kl, input logic [255:0] key, input string name);
    int nk;
    nk = 4 + 2 * kl;
    bus.start = 1'b1;
    bus.key_len = 2'(kl);
    bus.key_in = key;
    tick();
    bus.start = 1'b0;
    check({name, " busy after start"}, 128'(bus.busy), 128'(1));
    wait_done(name, 4 * (nk + 7) - nk);
    check({name, " nr"}, 128'(bus.nr), 128'(nk + 6));
    model_expand(nk, key);
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] r10_256;
    logic [255:0] rk;
    int n;
    int nk;
    logic err_seen;

    rcon_tab = '{8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    build_sbox();

    vt[0] = '{0, K128, 1, 128'ha0fafe1788542cb123a339392a6c7605};
    vt[1] = '{0, K128, 10, R10_128};
    vt[2] = '{0, K128, 11, 128'h0};
    vt[3] = '{1, K192, 12, 128'he98ba06f448c773c8ecc720401002202};
    vt[4] = '{2, K256, 14, 128'hfe4890d1e6188d0b046df344706c631e};

    bus.start = 1'b0; bus.key_len = 2'd0; bus.key_in = '0; bus.rd_en = 1'b0; bus.rd_round = 4'd0;
    bus4.start = 1'b0; bus4.key_len = 2'd0; bus4.key_in = '0; bus4.rd_en = 1'b0; bus4.rd_round = 4'd0;

    // Reset state
    #1;
    check("reset status", 128'({bus.busy, bus.done, bus.key_valid, bus.err, bus.nr}), 128'(0));
    check("reset rd_data", bus.rd_data, 128'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    read_rk(0, d);
    check("read before expansion r0", d, 128'h0);
    read_rk(5, d);
    check("read before expansion r5", d, 128'h0);

    // Known-answer table
    for (int i = 0; i < 5; i++) begin
      expand(vt[i].kl, vt[i].key, $sformatf("vec%0d", i));
      read_rk(vt[i].round, d);
      check($sformatf("vec%0d round%0d", i, vt[i].round), d, vt[i].exp);
      check($sformatf("vec%0d done pulse ends", i), 128'(bus.done), 128'(0));
    end

    // Illegal key_len: err pulse, AES-256 schedule untouched
    bus.start = 1'b1; bus.key_len = 2'd3; bus.key_in = K128;
    tick();
    bus.start = 1'b0;
    check("kl3 err", 128'({bus.err, bus.busy, bus.key_valid}), 128'(3'b101));
    tick();
    check("kl3 err one cycle", 128'(bus.err), 128'(0));
    read_rk(14, d);
    check("kl3 old schedule", d, 128'hfe4890d1e6188d0b046df344706c631e);

    // MAX_NK=4 instance rejects AES-256, then runs AES-128
    bus4.start = 1'b1; bus4.key_len = 2'd2; bus4.key_in = K256;
    tick();
    bus4.start = 1'b0;
    check("maxnk4 err", 128'({bus4.err, bus4.busy}), 128'(2'b10));
    bus4.start = 1'b1; bus4.key_len = 2'd0; bus4.key_in = K128;
    tick();
    bus4.start = 1'b0;
    n = 0;
    while (bus4.busy === 1'b1 && n < 200) begin n++; tick(); end
    check("maxnk4 busy cycles", 128'(n), 128'(40));
    bus4.rd_en = 1'b1; bus4.rd_round = 4'd10;
    tick();
    bus4.rd_en = 1'b0;
    check("maxnk4 round10", bus4.rd_data, R10_128);

    // Start while busy is ignored
    bus.start = 1'b1; bus.key_len = 2'd0; bus.key_in = K128;
    tick();
    bus.start = 1'b0;
    n = 0; err_seen = 1'b0;
    while (bus.busy === 1'b1 && n < 200) begin
      bus.start = (n == 10);
      bus.key_len = 2'd2;
      bus.key_in = K256;
      n++;
      tick();
      err_seen = err_seen | bus.err;
    end
    bus.start = 1'b0;
    check("busy start cycles", 128'(n), 128'(40));
    check("busy start no err", 128'(err_seen), 128'(0));
    read_rk(10, d);
    check("busy start round10", d, R10_128);

    // Reset in the middle of an expansion
    bus.start = 1'b1; bus.key_len = 2'd0; bus.key_in = K256;
    tick();
    bus.start = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check("midreset status", 128'({bus.busy, bus.done, bus.key_valid, bus.err, bus.nr}), 128'(0));
    check("midreset rd_data", bus.rd_data, 128'h0);
    tick();
    rst_n = 1'b1;
    tick();
    read_rk(0, d);
    check("midreset read invalid", d, 128'h0);
    expand(0, K128, "after reset");
    read_rk(10, d);
    check("after reset round10", d, R10_128);

    // Back-to-back: read on the start edge returns the previous schedule
    expand(2, K256, "b2b256");
    r10_256 = model_rk(10);
    bus.start = 1'b1; bus.key_len = 2'd0; bus.key_in = K128;
    bus.rd_en = 1'b1; bus.rd_round = 4'd10;
    tick();
    bus.start = 1'b0; bus.rd_en = 1'b0;
    check("b2b read on start edge", bus.rd_data, r10_256);
    check("b2b busy", 128'(bus.busy), 128'(1));
    wait_done("b2b128", 40);
    read_rk(10, d);
    check("b2b round10", d, R10_128);
    read_rk(11, d);
    check("b2b round11", d, 128'h0);

    // Random keys against the reference model
    for (int it = 0; it < 9; it++) begin
      for (int w = 0; w < 8; w++) rk[255-32*w -: 32] = $urandom;
      nk = 4 + 2 * (it % 3);
      expand(it % 3, rk, $sformatf("rand%0d", it));
      for (int r = 0; r <= nk + 6; r++) begin
        read_rk(r, d);
        check($sformatf("rand%0d nk%0d round%0d", it, nk, r), d, model_rk(r));
      end
      read_rk(nk + 7 + int'($urandom_range(0, 8 - nk)), d);
      check($sformatf("rand%0d beyond nr", it), d, 128'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
